// File: rtl/mdu_sequencer_pkg.sv
// mdu_sequencer_pkg
//   Shared definitions for the multiply/divide unit sequencer. The opcode
//   encoding is the same one the controller decoder uses to produce op and
//   mdu_d. The default busy latencies are also defined here.
package mdu_sequencer_pkg;

  localparam logic [2:0] MDU_NONE  = 3'b000;
  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_MULTU = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;
  localparam logic [2:0] MDU_DIVU  = 3'b100;
  localparam logic [2:0] MDU_MTHI  = 3'b101;
  localparam logic [2:0] MDU_MTLO  = 3'b110;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  // True for the four opcodes that occupy the unit for multiple cycles.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sequencer_arith.sv
// mdu_sequencer_arith
//   Purely combinational multiply/divide datapath. It keeps the signed and
//   unsigned arithmetic out of the sequencer FSM.
// Ports
//   op      in   3   MDU opcode
//   a, b    in   32  operands (rs, rt)
//   res_hi  out  32  upper product word, or the remainder
//   res_lo  out  32  lower product word, or the quotient
//   div0    out  1   op is DIV/DIVU with b == 0; the result must not be committed
module mdu_sequencer_arith
  import mdu_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic        [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic        [31:0] q_u;
  logic        [31:0] r_u;
  logic               b_zero;
  logic               div_ovf;

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign b_zero  = (b == 32'd0);
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign div0    = b_zero && ((op == MDU_DIV) || (op == MDU_DIVU));

  // Dividers are steered away from b==0 and away from the one signed
  // overflow case. This keeps the results defined. The overflow case is
  // pinned to the architectural answer (quotient wraps, remainder is 0).
  always_comb begin
    q_s = '0;
    r_s = '0;
    q_u = '0;
    r_u = '0;
    if (!b_zero) begin
      q_u = a / b;
      r_u = a % b;
      if (div_ovf) begin
        q_s = 32'sh8000_0000;
        r_s = '0;
      end else begin
        q_s = $signed(a) / $signed(b);
        r_s = $signed(a) % $signed(b);
      end
    end
  end

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV: begin
        res_hi = r_s;
        res_lo = q_s;
      end
      MDU_DIVU: begin
        res_hi = r_u;
        res_lo = q_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer
//   Sequences the multi-cycle multiply/divide unit that sits beside the
//   E-stage ALU. The result is computed and captured when the op issues. A
//   down-counter then models the fixed latency. HI/LO are updated only when
//   the counter expires.
// Ports
//   clk       in   1   clock, all state on posedge
//   rst       in   1   synchronous active-low reset
//   start     in   1   E-stage MDU op valid
//   op        in   3   E-stage MDU opcode
//   a, b      in   32  forwarded rs / rt values
//   mdu_d     in   1   D-stage instruction uses the MDU or HI/LO
//   busy      out  1   mult/div in progress
//   md_stall  out  1   stall request to the hazard unit
//   hi, lo    out  32  architectural HI/LO registers
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mdu_d,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  mdu_state_t        state;
  mdu_state_t        state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [31:0]       pend_hi;
  logic [31:0]       pend_lo;
  logic              pend_div0;
  logic [31:0]       res_hi;
  logic [31:0]       res_lo;
  logic              res_div0;
  logic              issue;
  logic              commit;
  logic              wr_hi;
  logic              wr_lo;

  mdu_sequencer_arith u_arith (
    .op     (op),
    .a      (a),
    .b      (b),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .div0   (res_div0)
  );

  // While RUN is active, any start is ignored. The pipeline stalls the
  // instructions that could issue one, so nothing is lost.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    issue      = 1'b0;
    commit     = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (is_muldiv(op)) begin
            issue      = 1'b1;
            state_next = ST_RUN;
            if ((op == MDU_DIV) || (op == MDU_DIVU))
              cnt_next = CNT_W'(DIV_CYCLES - 1);
            else
              cnt_next = CNT_W'(MULT_CYCLES - 1);
          end else if (op == MDU_MTHI) begin
            wr_hi = 1'b1;
          end else if (op == MDU_MTLO) begin
            wr_lo = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (cnt == '0) begin
          commit     = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      pend_div0 <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (issue) begin
        pend_hi   <= res_hi;
        pend_lo   <= res_lo;
        pend_div0 <= res_div0;
      end
      // A divide by zero still takes its full latency, but it leaves HI/LO as they were.
      if (commit && !pend_div0) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
      if (wr_hi) hi <= a;
      if (wr_lo) lo <= a;
    end
  end

  assign busy     = (state == ST_RUN);
  assign md_stall = mdu_d & (busy | (start & is_muldiv(op)));

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mdu_d;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int compared;
  int mismatched;
  logic illegal_ok;

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .mdu_d    (mdu_d),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // In a legal stream, no start of any kind may arrive while the unit is busy.
  always @(negedge clk) begin
    if (rst === 1'b1 && start === 1'b1 && busy === 1'b1 && !illegal_ok) begin
      mismatched++;
      $display("[TB] FAIL legal_stream: start=1 while busy=1 (required start=0)");
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int n);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = MDU_NONE; a = '0; b = '0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic mt_write(input logic [2:0] o, input logic [31:0] x);
    @(negedge clk);
    start = 1'b1; op = o; a = x;
    @(negedge clk);
    start = 1'b0; op = MDU_NONE; a = '0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; op = MDU_NONE; a = '0; b = '0; mdu_d = 1'b1;
    repeat (2) @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    compared++; if (hi !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_hi: got %h want 0", hi); end
    compared++; if (lo !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_lo: got %h want 0", lo); end
    compared++; if (md_stall !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall: got %b want 0", md_stall); end
    rst = 1'b1; mdu_d = 1'b0;
    mt_write(MDU_MTHI, 32'h55);
    compared++; if (hi !== 32'h55) begin mismatched++; $display("[TB] FAIL pre_reset_hi: got %h want 55", hi); end
    @(negedge clk);
    start = 1'b1; op = MDU_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = MDU_NONE;
    repeat (3) @(negedge clk);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL midrun_busy: got %b want 1", busy); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrun_reset_busy: got %b want 0", busy); end
    compared++; if (hi !== 32'd0 || lo !== 32'd0) begin mismatched++; $display("[TB] FAIL midrun_reset_hilo: got %h/%h want 0/0", hi, lo); end
    repeat (12) @(negedge clk);
    compared++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      mismatched++; $display("[TB] FAIL no_late_commit: got hi=%h lo=%h busy=%b want 0/0/0", hi, lo, busy);
    end
  endtask

  task automatic test_mult;
    int n;
    run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, n);
    compared++; if (n !== 5) begin mismatched++; $display("[TB] FAIL mult_busy: got %0d want 5", n); end
    compared++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      mismatched++; $display("[TB] FAIL mult_result: got %h_%h want ffffffff_ffffffeb", hi, lo);
    end
    run_op(MDU_MULTU, 32'hFFFF_FFFD, 32'd7, n);
    compared++; if (n !== 5) begin mismatched++; $display("[TB] FAIL multu_busy: got %0d want 5", n); end
    compared++; if (hi !== 32'd6 || lo !== 32'hFFFF_FFEB) begin
      mismatched++; $display("[TB] FAIL multu_result: got %h_%h want 00000006_ffffffeb", hi, lo);
    end
  endtask

  task automatic test_div;
    int n;
    run_op(MDU_DIVU, 32'd100, 32'd7, n);
    compared++; if (n !== 10) begin mismatched++; $display("[TB] FAIL divu_busy: got %0d want 10", n); end
    compared++; if (lo !== 32'd14 || hi !== 32'd2) begin
      mismatched++; $display("[TB] FAIL divu_result: got lo=%h hi=%h want lo=e hi=2", lo, hi);
    end
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, n);
    compared++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      mismatched++; $display("[TB] FAIL div_neg_dividend: got lo=%h hi=%h want lo=fffffffd hi=ffffffff", lo, hi);
    end
    run_op(MDU_DIV, 32'd7, 32'hFFFF_FFFE, n);
    compared++; if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
      mismatched++; $display("[TB] FAIL div_neg_divisor: got lo=%h hi=%h want lo=fffffffd hi=1", lo, hi);
    end
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    compared++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      mismatched++; $display("[TB] FAIL div_overflow: got lo=%h hi=%h want lo=80000000 hi=0", lo, hi);
    end
  endtask

  task automatic test_stall;
    int n;
    int bad;
    @(negedge clk);
    start = 1'b1; op = MDU_MULT; a = 32'd3; b = 32'd4; mdu_d = 1'b1;
    #1;
    compared++; if (md_stall !== 1'b1 || busy !== 1'b0) begin
      mismatched++; $display("[TB] FAIL stall_issue: got stall=%b busy=%b want 1/0", md_stall, busy);
    end
    @(negedge clk);
    start = 1'b0; op = MDU_NONE;
    n = 0; bad = 0;
    while (busy === 1'b1 && n < 40) begin
      #1;
      if (md_stall !== 1'b1) bad++;
      n++;
      @(negedge clk);
    end
    #1;
    compared++; if (n !== 5 || bad !== 0) begin
      mismatched++; $display("[TB] FAIL stall_busy: got busy=%0d unstalled=%0d want 5/0", n, bad);
    end
    compared++; if (md_stall !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_release: got %b want 0", md_stall); end
    @(negedge clk);
    start = 1'b1; op = MDU_MULTU; mdu_d = 1'b0;
    bad = 0;
    #1; if (md_stall !== 1'b0) bad++;
    @(negedge clk);
    start = 1'b0; op = MDU_NONE;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      #1;
      if (md_stall !== 1'b0) bad++;
      n++;
      @(negedge clk);
    end
    compared++; if (bad !== 0 || n !== 5) begin
      mismatched++; $display("[TB] FAIL nostall_mdu_d0: got stalled=%0d busy=%0d want 0/5", bad, n);
    end
  endtask

  task automatic test_div0;
    int n;
    mt_write(MDU_MTHI, 32'd5);
    mt_write(MDU_MTLO, 32'd6);
    run_op(MDU_DIV, 32'd9, 32'd0, n);
    compared++; if (n !== 10) begin mismatched++; $display("[TB] FAIL div0_busy: got %0d want 10", n); end
    compared++; if (hi !== 32'd5 || lo !== 32'd6) begin
      mismatched++; $display("[TB] FAIL div0_hilo: got hi=%h lo=%h want 5/6", hi, lo);
    end
    run_op(MDU_MULTU, 32'd9, 32'd0, n);
    compared++; if (hi !== 32'd0 || lo !== 32'd0) begin
      mismatched++; $display("[TB] FAIL mult_by_zero: got hi=%h lo=%h want 0/0", hi, lo);
    end
  endtask

  task automatic test_mt;
    int n;
    logic [31:0] lo_before;
    @(negedge clk);
    start = 1'b1; op = MDU_MTHI; a = 32'h1234; mdu_d = 1'b1;
    #1;
    compared++; if (md_stall !== 1'b0) begin mismatched++; $display("[TB] FAIL mthi_stall: got %b want 0", md_stall); end
    @(negedge clk);
    start = 1'b0; op = MDU_NONE; a = '0; mdu_d = 1'b0;
    compared++; if (hi !== 32'h1234 || busy !== 1'b0) begin
      mismatched++; $display("[TB] FAIL mthi: got hi=%h busy=%b want 1234/0", hi, busy);
    end
    lo_before = lo;
    @(negedge clk);
    start = 1'b1; op = MDU_MULTU; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0; op = MDU_NONE;
    @(negedge clk);
    illegal_ok = 1'b1;
    start = 1'b1; op = MDU_MTLO; a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; op = MDU_NONE; a = '0;
    illegal_ok = 1'b0;
    compared++; if (lo !== lo_before) begin
      mismatched++; $display("[TB] FAIL mtlo_in_run: got lo=%h want %h", lo, lo_before);
    end
    n = 2;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    compared++; if (n !== 5) begin mismatched++; $display("[TB] FAIL mtlo_in_run_busy: got %0d want 5", n); end
    compared++; if (hi !== 32'd0 || lo !== 32'd6) begin
      mismatched++; $display("[TB] FAIL mtlo_in_run_commit: got hi=%h lo=%h want 0/6", hi, lo);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    illegal_ok = 1'b0;
    rst = 1'b0; start = 1'b0; op = MDU_NONE; a = '0; b = '0; mdu_d = 1'b0;
    test_reset;
    test_mult;
    test_div;
    test_stall;
    test_div0;
    test_mt;
    repeat (2) @(negedge clk);
    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
